// File: rtl/arbitro_acumulador_if.sv
// Requester, datapath-drive and result bundle around arbitro_acumulador.
// master = requesters plus datapath feedback, slave = the arbiter.
interface arbitro_acumulador_if #(
  parameter int DATA_W = 3,
  parameter int SEL_W  = 2,
  parameter int ACC_W  = 6,
  parameter int CNT_W  = 4
);
  logic [1:0]        i_req_valid;
  logic [SEL_W-1:0]  i_req0_sel;
  logic [SEL_W-1:0]  i_req1_sel;
  logic [DATA_W-1:0] i_req0_data1;
  logic [DATA_W-1:0] i_req1_data1;
  logic [DATA_W-1:0] i_req0_data2;
  logic [DATA_W-1:0] i_req1_data2;
  logic [CNT_W-1:0]  i_req0_count;
  logic [CNT_W-1:0]  i_req1_count;
  logic [1:0]        o_req_ready;

  logic [SEL_W-1:0]  o_sel;
  logic [DATA_W-1:0] o_data1;
  logic [DATA_W-1:0] o_data2;
  logic              o_acc_clr;
  logic              o_acc_en;
  logic [ACC_W-1:0]  i_dp_data;
  logic              i_dp_overflow;

  logic [ACC_W-1:0]  o_result;
  logic              o_result_ovf;
  logic              o_done;
  logic              o_done_id;
  logic              o_busy;

  modport master (
    output i_req_valid, i_req0_sel, i_req1_sel, i_req0_data1, i_req1_data1,
           i_req0_data2, i_req1_data2, i_req0_count, i_req1_count,
    input  o_req_ready,
    input  o_sel, o_data1, o_data2, o_acc_clr, o_acc_en,
    output i_dp_data, i_dp_overflow,
    input  o_result, o_result_ovf, o_done, o_done_id, o_busy
  );

  modport slave (
    input  i_req_valid, i_req0_sel, i_req1_sel, i_req0_data1, i_req1_data1,
           i_req0_data2, i_req1_data2, i_req0_count, i_req1_count,
    output o_req_ready,
    output o_sel, o_data1, o_data2, o_acc_clr, o_acc_en,
    input  i_dp_data, i_dp_overflow,
    output o_result, o_result_ovf, o_done, o_done_id, o_busy
  );
endinterface

// File: rtl/arbitro_acumulador.sv
// Round-robin owner of the shared adder/accumulator datapath; ARB_STICKY_OVF_EN makes overflow sticky over RUN+WAIT.
// Latency: handshake at T -> clear T+1, N accumulate cycles T+2..T+1+N, settle T+2+N, o_done at T+3+N.
// Backpressure: one command in flight; o_req_ready only in IDLE, requesters hold valid until granted.
module arbitro_acumulador #(
  parameter int DATA_W = 3,
  parameter int SEL_W  = 2,
  parameter int ACC_W  = 6,
  parameter int CNT_W  = 4
) (
  input  logic                clock,
  input  logic                i_rst_n,
  arbitro_acumulador_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_WAIT,
    S_DONE
  } state_t;

  typedef struct packed {
    logic              id;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic [CNT_W-1:0]  count;
  } cmd_t;

  state_t            state;
  state_t            state_nxt;
  cmd_t              cmd;
  cmd_t              req_cmd;
  logic [CNT_W-1:0]  cnt;
  logic              ptr;
  logic              win_id;
  logic              grant_en;
  logic [1:0]        req_rdy;
  logic              xfer;
  logic              ovf_sample;

  logic [ACC_W-1:0]  result;
  logic              result_ovf;
  logic              done_id;

  logic              acc_clr;
  logic              acc_en;
  logic [SEL_W-1:0]  drv_sel;
  logic [DATA_W-1:0] drv_data1;
  logic [DATA_W-1:0] drv_data2;

  // Pointer only breaks ties; a lone requester always wins.
  always_comb begin
    win_id = bus.i_req_valid[1];
    if (&bus.i_req_valid) begin
      win_id = ptr;
    end
  end

  assign grant_en = (state == S_IDLE) && (|bus.i_req_valid);
  assign req_rdy  = grant_en ? (win_id ? 2'b10 : 2'b01) : 2'b00;
  assign xfer     = |(bus.i_req_valid & req_rdy);

  always_comb begin
    req_cmd = '0;
    if (win_id) begin
      req_cmd.id    = 1'b1;
      req_cmd.sel   = bus.i_req1_sel;
      req_cmd.data1 = bus.i_req1_data1;
      req_cmd.data2 = bus.i_req1_data2;
      req_cmd.count = bus.i_req1_count;
    end else begin
      req_cmd.id    = 1'b0;
      req_cmd.sel   = bus.i_req0_sel;
      req_cmd.data1 = bus.i_req0_data1;
      req_cmd.data2 = bus.i_req0_data2;
      req_cmd.count = bus.i_req0_count;
    end
  end

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    acc_clr   = 1'b0;
    acc_en    = 1'b0;
    drv_sel   = '0;
    drv_data1 = '0;
    drv_data2 = '0;
    unique case (state)
      S_IDLE: begin
        if (xfer) begin
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        acc_clr   = 1'b1;
        state_nxt = (cmd.count == '0) ? S_WAIT : S_RUN;
      end
      S_RUN: begin
        acc_en    = 1'b1;
        drv_sel   = cmd.sel;
        drv_data1 = cmd.data1;
        drv_data2 = cmd.data2;
        if (cnt <= CNT_W'(1)) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        state_nxt = S_DONE;
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cmd <= '0;
      cnt <= '0;
      ptr <= 1'b0;
    end else begin
      if (xfer) begin
        cmd <= req_cmd;
        cnt <= req_cmd.count;
        ptr <= ~win_id;
      end else if (state == S_RUN) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

`ifdef ARB_STICKY_OVF_EN
  logic sticky_ovf;

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sticky_ovf <= 1'b0;
    end else if (state == S_CLEAR) begin
      sticky_ovf <= 1'b0;
    end else if ((state == S_RUN) || (state == S_WAIT)) begin
      sticky_ovf <= sticky_ovf | bus.i_dp_overflow;
    end
  end

  // The WAIT-cycle sample joins the flag on the same edge it is captured.
  assign ovf_sample = sticky_ovf | bus.i_dp_overflow;
`else
  assign ovf_sample = bus.i_dp_overflow;
`endif

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      result     <= '0;
      result_ovf <= 1'b0;
      done_id    <= 1'b0;
    end else if (state == S_WAIT) begin
      result     <= bus.i_dp_data;
      result_ovf <= ovf_sample;
      done_id    <= cmd.id;
    end
  end

  assign bus.o_req_ready  = req_rdy;
  assign bus.o_sel        = drv_sel;
  assign bus.o_data1      = drv_data1;
  assign bus.o_data2      = drv_data2;
  assign bus.o_acc_clr    = acc_clr;
  assign bus.o_acc_en     = acc_en;
  assign bus.o_result     = result;
  assign bus.o_result_ovf = result_ovf;
  assign bus.o_done       = (state == S_DONE);
  assign bus.o_done_id    = done_id;
  assign bus.o_busy       = (state != S_IDLE);

  a_ready_onehot: assert property (@(posedge clock) disable iff (!i_rst_n)
    $onehot0(req_rdy));
  a_no_grant_busy: assert property (@(posedge clock) disable iff (!i_rst_n)
    (state != S_IDLE) |-> (req_rdy == 2'b00));
  a_clear_single: assert property (@(posedge clock) disable iff (!i_rst_n)
    (state == S_CLEAR) |=> (state != S_CLEAR));
  a_done_single: assert property (@(posedge clock) disable iff (!i_rst_n)
    (state == S_DONE) |=> (state == S_IDLE));

endmodule

// File: tb/tb_arbitro_acumulador.sv
// Bench for arbitro_acumulador: stand-in datapath, handshake-driven scoreboard, negedge monitor.
// Built with or without ARB_STICKY_OVF_EN; the reference model follows the same define.
module tb_arbitro_acumulador;
  localparam int DATA_W = 3;
  localparam int SEL_W  = 2;
  localparam int ACC_W  = 6;
  localparam int CNT_W  = 4;
`ifdef ARB_STICKY_OVF_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic clock = 1'b0;
  logic i_rst_n;
  always #5 clock = ~clock;

  arbitro_acumulador_if #(.DATA_W(DATA_W), .SEL_W(SEL_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

  arbitro_acumulador #(.DATA_W(DATA_W), .SEL_W(SEL_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clock  (clock),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: wait bound expired @cyc %0d", name, cyc);
  endtask

  // Stand-in selective adder + registered accumulator.
  function automatic int op_val(input logic [1:0] s, input logic [2:0] a, input logic [2:0] b);
    case (s)
      2'd0:    return int'(a) + int'(b);
      2'd1:    return int'(a);
      2'd2:    return int'(b);
      default: return int'(a) + 2 * int'(b);
    endcase
  endfunction

  logic [ACC_W-1:0] dp_acc;
  logic             dp_ovf;
  logic             inj = 1'b0;

  always @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      dp_acc <= '0;
      dp_ovf <= 1'b0;
    end else if (bus.o_acc_clr) begin
      dp_acc <= '0;
      dp_ovf <= 1'b0;
    end else if (bus.o_acc_en) begin
      dp_acc <= ACC_W'((int'(dp_acc) + op_val(bus.o_sel, bus.o_data1, bus.o_data2)) % 64);
      dp_ovf <= (int'(dp_acc) + op_val(bus.o_sel, bus.o_data1, bus.o_data2)) >= 64;
    end
  end
  assign bus.i_dp_data     = dp_acc;
  assign bus.i_dp_overflow = dp_ovf | inj;

  // Reference: N additions of the selected operand into a cleared 6-bit accumulator.
  function automatic void ref_model(input logic [1:0] s, input logic [2:0] a, input logic [2:0] b,
                                    input int n, input bit injected,
                                    output logic [5:0] res, output bit ovf);
    int acc = 0;
    bit any = 1'b0;
    bit last = 1'b0;
    for (int k = 0; k < n; k++) begin
      acc  = acc + op_val(s, a, b);
      last = (acc >= 64);
      any  = any | last;
      acc  = acc % 64;
    end
    res = 6'(acc);
    ovf = STICKY ? (any | injected) : last;
  endfunction

  typedef struct {
    bit         id;
    logic [1:0] sel;
    logic [2:0] d1;
    logic [2:0] d2;
    int         n;
    logic [5:0] res;
    bit         ovf;
    int         t0;
  } exp_t;

  exp_t       exp_q[$];
  bit         grant_log[$];
  bit         model_ptr = 1'b0;
  bit         exp_inj   = 1'b0;
  logic [5:0] held_res  = '0;
  bit         held_ovf  = 1'b0;
  bit         held_id   = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  exp_t       cur;
  exp_t       nw;
  bit         act, exp_busy, in_run, in_clr, is_done, win;
  logic [1:0] exp_ready, hs;
  logic [5:0] r_res;
  bit         r_ovf;

  always @(negedge clock) begin
    if (!i_rst_n) begin
      exp_q.delete();
      model_ptr = 1'b0;
      held_res  = '0;
      held_ovf  = 1'b0;
      held_id   = 1'b0;
    end else begin
      act = (exp_q.size() > 0);
      if (act) cur = exp_q[0];
      exp_busy = act && (cyc >= cur.t0 + 1) && (cyc <= cur.t0 + 3 + cur.n);
      in_clr   = act && (cyc == cur.t0 + 1);
      in_run   = act && (cyc >= cur.t0 + 2) && (cyc <= cur.t0 + 1 + cur.n);
      is_done  = act && (cyc == cur.t0 + 3 + cur.n);

      chk("drive", 32'({bus.o_acc_en, bus.o_acc_clr, bus.o_sel, bus.o_data1, bus.o_data2}),
          32'({in_run, in_clr, in_run ? cur.sel : 2'd0, in_run ? cur.d1 : 3'd0, in_run ? cur.d2 : 3'd0}));
      chk("busy", 32'(bus.o_busy), 32'(exp_busy));
      chk("done", 32'(bus.o_done), 32'(is_done));
      if (is_done) begin
        chk("done_id", 32'(bus.o_done_id), 32'(cur.id));
        chk("result", 32'(bus.o_result), 32'(cur.res));
        chk("result_ovf", 32'(bus.o_result_ovf), 32'(cur.ovf));
        held_res = cur.res;
        held_ovf = cur.ovf;
        held_id  = cur.id;
        void'(exp_q.pop_front());
      end else begin
        chk("held", 32'({bus.o_result, bus.o_result_ovf, bus.o_done_id}),
            32'({held_res, held_ovf, held_id}));
      end

      exp_ready = 2'b00;
      if (!exp_busy && (|bus.i_req_valid)) begin
        win       = (&bus.i_req_valid) ? model_ptr : bus.i_req_valid[1];
        exp_ready = win ? 2'b10 : 2'b01;
      end
      chk("ready", 32'(bus.o_req_ready), 32'(exp_ready));

      hs = bus.i_req_valid & bus.o_req_ready;
      if (hs != 2'b00) begin
        nw.id  = hs[1];
        nw.sel = nw.id ? bus.i_req1_sel   : bus.i_req0_sel;
        nw.d1  = nw.id ? bus.i_req1_data1 : bus.i_req0_data1;
        nw.d2  = nw.id ? bus.i_req1_data2 : bus.i_req0_data2;
        nw.n   = int'(nw.id ? bus.i_req1_count : bus.i_req0_count);
        ref_model(nw.sel, nw.d1, nw.d2, nw.n, exp_inj, r_res, r_ovf);
        nw.res = r_res;
        nw.ovf = r_ovf;
        nw.t0  = cyc;
        exp_q.push_back(nw);
        grant_log.push_back(nw.id);
        model_ptr = ~nw.id;
      end
    end
  end

  task automatic set_fields(input bit id, input logic [1:0] s, input logic [2:0] a,
                            input logic [2:0] b, input logic [3:0] n);
    if (id) begin
      bus.i_req1_sel = s; bus.i_req1_data1 = a; bus.i_req1_data2 = b; bus.i_req1_count = n;
    end else begin
      bus.i_req0_sel = s; bus.i_req0_data1 = a; bus.i_req0_data2 = b; bus.i_req0_count = n;
    end
  endtask

  function automatic logic [3:0] rand_count();
    return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 4));
  endfunction

  task automatic rand_fields(input bit id, input logic [3:0] n);
    set_fields(id, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), n);
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic issue(input bit id, input logic [1:0] s, input logic [2:0] a,
                       input logic [2:0] b, input logic [3:0] n);
    bit ok = 1'b0;
    set_fields(id, s, a, b, n);
    bus.i_req_valid[id] = 1'b1;
    for (int k = 0; k < 60 && !ok; k++) begin
      @(negedge clock);
      ok = bus.o_req_ready[id];
    end
    if (!ok) timeout("issue_grant");
    @(posedge clock); #1;
    bus.i_req_valid[id] = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clock);
      ok = !bus.o_busy;
    end
    if (!ok) timeout("wait_idle");
    @(posedge clock); #1;
  endtask

  task automatic wait_en();
    bit ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clock);
      ok = bus.o_acc_en;
    end
    if (!ok) timeout("wait_acc_en");
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(bus.o_req_ready), 32'(0));
    chk({tag, "_drive"}, 32'({bus.o_sel, bus.o_data1, bus.o_data2, bus.o_acc_clr, bus.o_acc_en}), 32'(0));
    chk({tag, "_result"}, 32'({bus.o_result, bus.o_result_ovf}), 32'(0));
    chk({tag, "_done"}, 32'({bus.o_done, bus.o_done_id}), 32'(0));
    chk({tag, "_busy"}, 32'(bus.o_busy), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish @cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit got;
    i_rst_n = 1'b0;
    bus.i_req_valid = 2'b00;
    set_fields(1'b0, 2'd0, 3'd0, 3'd0, 4'd0);
    set_fields(1'b1, 2'd0, 3'd0, 3'd0, 4'd0);
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    @(posedge clock); #2;
    i_rst_n = 1'b1;
    @(posedge clock); #1;

    // Directed: 3+2 accumulated three times.
    issue(1'b0, 2'd0, 3'd3, 3'd2, 4'd3);
    wait_idle();
    chk("directed_result", 32'(bus.o_result), 32'(15));

    // Zero-count command from req1.
    issue(1'b1, 2'd0, 3'd7, 3'd7, 4'd0);
    wait_idle();

    // Both requesters valid continuously.
    grant_log.delete();
    bus.i_req_valid = 2'b11;
    for (int k = 0; k < 40; k++) begin
      rand_fields(1'b0, 4'd1);
      rand_fields(1'b1, 4'd1);
      @(posedge clock); #1;
    end
    bus.i_req_valid = 2'b00;
    wait_idle();
    for (int k = 0; k < 4; k++)
      chk("fair_order", (grant_log.size() > k) ? 32'(grant_log[k]) : 32'(2), 32'(k % 2));

    // Overflow pulse inside RUN that is gone by WAIT.
    exp_inj = 1'b1;
    issue(1'b0, 2'd1, 3'd1, 3'd0, 4'd4);
    wait_en();
    @(posedge clock); #1; inj = 1'b1;
    @(posedge clock); #1; inj = 1'b0;
    wait_idle();
    exp_inj = 1'b0;
    chk("inj_ovf", 32'(bus.o_result_ovf), 32'(STICKY));

    // req0 waits while req1 runs, with both command buses churning.
    issue(1'b1, 2'd2, 3'd5, 3'd6, 4'd6);
    bus.i_req_valid[0] = 1'b1;
    rand_fields(1'b0, rand_count());
    got = 1'b0;
    for (int k = 0; k < 60 && !got; k++) begin
      @(negedge clock);
      got = bus.o_req_ready[0];
      @(posedge clock); #1;
      if (!got) begin
        rand_fields(1'b0, rand_count());
        rand_fields(1'b1, rand_count());
      end
    end
    if (!got) timeout("busy_grant");
    bus.i_req_valid = 2'b00;
    wait_idle();

    // Abort in the middle of RUN.
    issue(1'b1, 2'd0, 3'd7, 3'd7, 4'd10);
    wait_en();
    @(posedge clock); #2;
    i_rst_n = 1'b0;
    #1;
    check_all_zero("abort");
    repeat (2) @(posedge clock);
    #2;
    i_rst_n = 1'b1;
    @(posedge clock); #1;
    grant_log.delete();
    bus.i_req_valid = 2'b11;
    rand_fields(1'b0, 4'd2);
    rand_fields(1'b1, 4'd2);
    got = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clock);
      got = |bus.o_req_ready;
    end
    if (!got) timeout("grant_after_reset");
    @(posedge clock); #1;
    bus.i_req_valid = 2'b00;
    wait_idle();
    chk("first_grant_after_reset", (grant_log.size() > 0) ? 32'(grant_log[0]) : 32'(2), 32'(0));

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      bus.i_req_valid = 2'($urandom_range(0, 3));
      rand_fields(1'b0, rand_count());
      rand_fields(1'b1, rand_count());
      @(posedge clock); #1;
    end
    bus.i_req_valid = 2'b00;
    wait_idle();
    repeat (2) @(posedge clock);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/arbitro_acumulador.md
# arbitro_acumulador

Round-robin controller that shares the selective-adder/accumulator datapath (`sumador_selectivo` + `realimentador`) between two requesters. It accepts one command per requester through a valid/ready handshake and clears the accumulator. It then drives operands and operation select for a programmed number of accumulate cycles, captures the accumulated result and overflow, and reports completion tagged with the requester ID. It sits between the requesters and the datapath's operand, select and enable inputs.

## Interface
- `DATA_W`, 3: operand width.
- `SEL_W`, 2: operation-select width.
- `ACC_W`, 6: accumulator width.
- `CNT_W`, 4: accumulate-count width.
- `clock`  in  1: single clock, rising edge.
- `i_rst_n`  in  1: reset, asynchronous, active-low.
- `i_req_valid`  in  2: bit i set means requester i presents a command.
- `i_req0_sel` / `i_req1_sel`  in  SEL_W: operation select.
- `i_req0_data1` / `i_req1_data1`, `i_req0_data2` / `i_req1_data2`  in  DATA_W: operands.
- `i_req0_count` / `i_req1_count`  in  CNT_W: number of accumulate cycles.
- `o_req_ready`  out  2: grant/accept for each requester.
- `o_sel`  out  SEL_W, `o_data1` / `o_data2`  out  DATA_W: datapath drive.
- `o_acc_clr`  out  1: synchronous accumulator clear.
- `o_acc_en`  out  1: accumulate enable.
- `i_dp_data`  in  ACC_W: registered accumulator value.
- `i_dp_overflow`  in  1: datapath overflow flag.
- `o_result`  out  ACC_W, `o_result_ovf`  out  1: last captured result.
- `o_done`  out  1: one-cycle completion pulse.
- `o_done_id`  out  1: requester that owns `o_result`.
- `o_busy`  out  1: set in every state except IDLE.

## Operation
- FSM states: IDLE, CLEAR, RUN, WAIT, DONE.
- IDLE:
  - The arbiter picks a winner among the asserted `i_req_valid` bits. With both asserted, the priority pointer decides.
  - `o_req_ready[winner]` is asserted combinationally in IDLE only.
  - A transfer happens on `valid & ready`. It latches sel, data1, data2, count and the ID, toggles the pointer to the other requester, and moves the FSM to CLEAR.
  - With no valid request, the FSM stays in IDLE.
- CLEAR: `o_acc_clr`=1 for exactly one cycle, then RUN. If the latched count is 0, the FSM goes to WAIT instead.
- RUN:
  - `o_acc_en`=1.
  - `o_sel`, `o_data1` and `o_data2` carry the latched command.
  - An internal counter loads with count and decrements each cycle. The FSM leaves RUN after exactly count cycles and enters WAIT.
- WAIT: one settle cycle. Datapath drive is 0.
- DONE:
  - `o_result` ← `i_dp_data` and `o_result_ovf` ← overflow (see Configuration). Both register at the edge that ends WAIT.
  - `o_done`=1 and `o_done_id` = latched ID for one cycle.
  - Next state is IDLE. No grant is issued in DONE.
- Outside RUN, `o_sel`, `o_data1`, `o_data2` and `o_acc_en` are 0. `o_acc_clr` is 0 outside CLEAR.
- `o_result`, `o_result_ovf` and `o_done_id` hold their values until the next DONE.
- Dropping `i_req_valid` before `o_req_ready` has no effect. Requests arriving while busy see ready low and wait.
- Count 0 yields result 0 (just cleared) and overflow 0.

## Timing
- Reset state: FSM in IDLE, priority pointer = requester 0, counter 0. Every output is 0.
- Reset asserted mid-operation aborts immediately. No `o_done` is issued, and the outputs return to reset values asynchronously.
- Handshake at cycle T gives:
  - CLEAR at T+1;
  - RUN at T+2 … T+1+N;
  - WAIT at T+2+N;
  - `o_done` at T+3+N.
- For N=0: CLEAR at T+1, WAIT at T+2, `o_done` at T+3.
- Earliest next grant is T+4+N, in IDLE after DONE.
- Fairness: with both requesters continuously valid, grants alternate 0,1,0,1…

## Configuration
- `ARB_STICKY_OVF_EN` defined:
  - A sticky flag clears in CLEAR and ORs `i_dp_overflow` sampled in every RUN and WAIT cycle.
  - `o_result_ovf` = sticky flag at DONE.
- `ARB_STICKY_OVF_EN` undefined: `o_result_ovf` = `i_dp_overflow` sampled only at the WAIT→DONE edge.

## Test plan
- Reset, then req0 with sel=0, data 3/2, count=3 against the datapath model:
  - ready[0] pulses;
  - `o_acc_en` is high for 3 cycles;
  - `o_done` at T+6 with `o_done_id`=0 and result equal to the model's value.
- Both requesters valid continuously, count=1 each: grant order 0,1,0,1, and each `o_done_id` matches its grant.
- count=0 from req1: no `o_acc_en`, `o_done` at T+3, result=0, ovf=0.
- Overflow pulse mid-RUN that clears before WAIT: ovf=1 with `ARB_STICKY_OVF_EN` defined, ovf=0 without it.
- `i_rst_n` low during RUN: all outputs 0 at once, no `o_done`, and after release the first grant goes to req0.
- req0 valid while busy: ready[0] stays low until IDLE, and the latched command is unchanged by input changes during RUN.
